// File: rtl/ui_seg_display_pkg.sv
// Shared glyph codes, segment patterns, page encodings and snapshot record for the 7-seg display driver.
package ui_pkg;

  // 5-bit glyph codes: 0..15 are hex digits, the rest are special symbols.
  localparam logic [4:0] GL_H     = 5'd16;
  localparam logic [4:0] GL_L     = 5'd17;
  localparam logic [4:0] GL_T     = 5'd18;
  localparam logic [4:0] GL_DASH  = 5'd19;
  localparam logic [4:0] GL_BLANK = 5'd20;
  localparam logic [4:0] GL_A     = 5'd10;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_T     = 7'h07;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] PAGE_OPERANDS = 3'd0;
  localparam logic [2:0] PAGE_RESULT   = 3'd1;
  localparam logic [2:0] PAGE_OPADDR   = 3'd2;
  localparam logic [2:0] PAGE_HALT     = 3'd3;

  typedef struct packed {
    logic [2:0]  page;
    logic [15:0] alu_p;
    logic [15:0] alu_q;
    logic [15:0] res_hi;
    logic [15:0] res_lo;
    logic [2:0]  alu_op;
    logic [7:0]  max_addr;
    logic        halt;
  } snap_t;

  function automatic logic [4:0] hex_glyph(input logic [3:0] n);
    return {1'b0, n};
  endfunction

  // Nibble pos 3 is the most significant one.
  function automatic logic [3:0] nibble(input logic [15:0] w, input logic [1:0] pos);
    return w[{pos, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/ui_seg_display_if.sv
// CPU status inputs and display pins of the 7-seg driver, bundled as one port.
interface ui_seg_display_if;
  logic [2:0]  i_page_sel;
  logic [15:0] i_alu_P;
  logic [15:0] i_alu_Q;
  logic [15:0] i_result_high;
  logic [15:0] i_result_low;
  logic [2:0]  i_alu_op;
  logic [7:0]  i_max_addr;
  logic        i_halt;
  logic [7:0]  o_an_n;
  logic [7:0]  o_seg_n;

  modport master (
    output i_page_sel, i_alu_P, i_alu_Q, i_result_high, i_result_low,
    output i_alu_op, i_max_addr, i_halt,
    input  o_an_n, o_seg_n
  );

  modport slave (
    input  i_page_sel, i_alu_P, i_alu_Q, i_result_high, i_result_low,
    input  i_alu_op, i_max_addr, i_halt,
    output o_an_n, o_seg_n
  );
endinterface

// File: rtl/ui_seg_display_seg7_decoder.sv
// Combinational glyph code to active-low {g..a} segment pattern; unknown codes render blank.
module seg7_decoder
  import ui_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:     seg = SEG_0;
      5'd1:     seg = SEG_1;
      5'd2:     seg = SEG_2;
      5'd3:     seg = SEG_3;
      5'd4:     seg = SEG_4;
      5'd5:     seg = SEG_5;
      5'd6:     seg = SEG_6;
      5'd7:     seg = SEG_7;
      5'd8:     seg = SEG_8;
      5'd9:     seg = SEG_9;
      5'd10:    seg = SEG_A;
      5'd11:    seg = SEG_B;
      5'd12:    seg = SEG_C;
      5'd13:    seg = SEG_D;
      5'd14:    seg = SEG_E;
      5'd15:    seg = SEG_F;
      GL_H:     seg = SEG_H;
      GL_L:     seg = SEG_L;
      GL_T:     seg = SEG_T;
      GL_DASH:  seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ui_seg_display.sv
// Time-multiplexed 8-digit common-anode 7-seg driver with per-frame snapshot of page and CPU status.
// Outputs are registered one cycle after the slot counter/snapshot state; first BLANK_CYCLES of each slot are dark.
module ui_seg_display
  import ui_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input logic             i_clk,
  input logic             i_rst_n,
  ui_seg_display_if.slave bus
);

  localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             first;
  snap_t            snap;
  snap_t            live;
  logic             slot_end;
  logic             capture;
  logic [4:0]       glyph;
  logic             dp_lit;
  logic [6:0]       seg7;
  logic [7:0]       an_q;
  logic [7:0]       seg_q;

  assign slot_end = (cnt == CNT_LAST);
  // First clock after reset loads the snapshot so frame 0 shows live data.
  assign capture  = first || (slot_end && (idx == 3'd7));

  always_comb begin
    live          = '0;
    live.page     = bus.i_page_sel;
    live.alu_p    = bus.i_alu_P;
    live.alu_q    = bus.i_alu_Q;
    live.res_hi   = bus.i_result_high;
    live.res_lo   = bus.i_result_low;
    live.alu_op   = bus.i_alu_op;
    live.max_addr = bus.i_max_addr;
    live.halt     = bus.i_halt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt   <= '0;
      idx   <= 3'd0;
      first <= 1'b1;
      snap  <= '0;
    end else begin
      first <= 1'b0;
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (capture) begin
        snap <= live;
      end
    end
  end

  always_comb begin
    glyph  = GL_BLANK;
    dp_lit = 1'b0;
    case (snap.page)
      PAGE_OPERANDS: begin
        glyph  = hex_glyph(nibble(idx[2] ? snap.alu_p : snap.alu_q, idx[1:0]));
        dp_lit = (idx == 3'd4);
      end
      PAGE_RESULT: begin
        glyph  = hex_glyph(nibble(idx[2] ? snap.res_hi : snap.res_lo, idx[1:0]));
        dp_lit = (idx == 3'd4);
      end
      PAGE_OPADDR: begin
        case (idx)
          3'd7:    glyph = {2'b00, snap.alu_op};
          3'd1:    glyph = hex_glyph(snap.max_addr[7:4]);
          3'd0:    glyph = hex_glyph(snap.max_addr[3:0]);
          default: glyph = GL_BLANK;
        endcase
      end
      PAGE_HALT: begin
        if (idx[2]) begin
          if (snap.halt) begin
            case (idx[1:0])
              2'd3:    glyph = GL_H;
              2'd2:    glyph = GL_A;
              2'd1:    glyph = GL_L;
              default: glyph = GL_T;
            endcase
          end else begin
            glyph = GL_DASH;
          end
        end
      end
      default: glyph = GL_BLANK;
    endcase
  end

  seg7_decoder u_dec (
    .code (glyph),
    .seg  (seg7)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
    end else if (cnt < CNT_BLANK) begin
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
    end else begin
      an_q  <= ~(8'b1 << idx);
      seg_q <= {~dp_lit, seg7};
    end
  end

  assign bus.o_an_n  = an_q;
  assign bus.o_seg_n = seg_q;

endmodule
